e_pow_engine: RTL and testbench
===============================

// Module: e_pow_engine
// PURPOSE
//  Runtime-configurable multiword fixed-point power engine for the e-approximation datapath.
//  MODE 0 computes (1 + 2^-k)^(2^k) by k repeated squarings; MODE 1 squares a supplied operand k times (x^(2^k)).
//  A single word-serial product-scanning multiplier is reused for every squaring; the result is held until the next start.
// PARAMETERS
//  WORD_W      16   bits per word
//  WORDS        8   words per operand/result (word 0 = least significant)
//  INT_WORDS    1   integer words at the top; FRAC_BITS = WORD_W*(WORDS-INT_WORDS)
//  MAX_LOG2_N  15   largest accepted k; elaboration error unless 1 <= MAX_LOG2_N < FRAC_BITS
//  K_W          5   width of log2_n; elaboration error unless 2^K_W > MAX_LOG2_N
// PORTS
//  clk      in   1                clock, all logic on rising edge
//  rst      in   1                synchronous reset, active-high
//  start    in   1                request; accepted only in IDLE
//  mode     in   1                0 = e-series init, 1 = square operand
//  log2_n   in   K_W              k = number of squarings
//  operand  in   WORD_W x WORDS   MODE 1 input value, fixed point
//  busy     out  1                high from accept until done
//  done     out  1                level; high in DONE until next accepted start
//  err      out  1                start rejected (k==0 or k>MAX_LOG2_N); valid with done
//  ovf      out  1                sticky: nonzero bits discarded above the integer field
//  iter     out  K_W              squarings completed in current run
//  result   out  WORD_W x WORDS   fixed-point result, stable while done
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, err, ovf = 0; iter = 0; result all-zero. Applies mid-run; the run is discarded.
//  - States: IDLE -> LOAD -> MAC -> WB -> (MAC if iter<k else DONE); DONE -> LOAD on start; any state -> IDLE on rst.
//  - Accept, cycle T: start=1 in IDLE or DONE. Capture mode, log2_n, operand. Clear done, err, ovf, iter.
//  - start while busy is ignored; inputs are not re-sampled.
//  - Illegal k: DONE at T+1 with err=1, result unchanged, busy never set.
//  - LOAD (T+1):
//    - MODE 0: X = 2^FRAC_BITS + 2^(FRAC_BITS-k).
//    - MODE 1: X = operand.
//  - MAC: product scanning, one WORD_W x WORD_W multiply per cycle.
//    - Columns c = 0..2*WORDS-2; each column i ascending over all valid pairs X[i]*X[c-i]. Exactly WORDS^2 cycles.
//    - Accumulator width 2*WORD_W + $clog2(WORDS) + 1.
//    - At the last term of a column: emit the low word to P[c], then shift the accumulator right by WORD_W.
//    - The residue after column 2*WORDS-2 is P[2*WORDS-1].
//  - WB (1 cycle): X = P >> FRAC_BITS, truncating (floor).
//    - ovf |= OR of the P words above WORDS+FRAC_BITS/WORD_W.
//    - iter++.
//  - DONE: result = X, done=1, busy=0. Legal run: done rises at T + 2 + k*(WORDS^2+1).
//  - result changes only on entry to DONE or reset, never mid-run.
//  - iter is visible live during the run.
//  - MODE 0 never sets ovf for legal k (value < 3).
// TESTING
//  1. MODE 0, k=1 -> done at T+2+65; result[7]=0x0002, result[6]=0x4000, rest 0 (2.25); err=0, ovf=0
//  2. MODE 0, k=2 -> result[7]=0x0002, result[6]=0x7100, rest 0 (2.44140625); done at T+132
//  3. MODE 1, operand 1.5 (result[7]=1, [6]=0x8000), k=3 -> result[7]=0x0019, [6]=0xA100 (25.62890625), ovf=0
//  4. MODE 1, operand 256.0, k=2 -> result 0, ovf=1; then k=0 start -> done at T+1, err=1, result held
//  5. MODE 0, k=15, start pulsed again mid-run -> ignored; result within 2^-14 below e vs model; iter steps 1..15
//  6. rst asserted mid-MAC -> next cycle IDLE, outputs all zero; fresh k=1 run then matches scenario 1

Source files
------------

// File: rtl/e_pow_engine.sv
`default_nettype none
// ============================================================================
// e_pow_engine : word-serial fixed-point power engine, (1+2^-k)^(2^k) or x^(2^k)
// Rev 1.0
// ============================================================================
module e_pow_engine #(
  parameter int WORD_W     = 16,
  parameter int WORDS      = 8,
  parameter int INT_WORDS  = 1,
  parameter int MAX_LOG2_N = 15,
  parameter int K_W        = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [K_W-1:0]                 log2_n,
  input  logic [WORDS-1:0][WORD_W-1:0]   operand,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           ovf,
  output logic [K_W-1:0]                 iter,
  output logic [WORDS-1:0][WORD_W-1:0]   result
);

  localparam int FRAC_W    = WORDS - INT_WORDS;
  localparam int FRAC_BITS = WORD_W * FRAC_W;
  localparam int TOT_W     = WORD_W * WORDS;
  localparam int ACC_W     = 2 * WORD_W + $clog2(WORDS) + 1;
  localparam int IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW        = $clog2(2 * WORDS);
  localparam int PH_W      = 2 * WORDS - FRAC_W;
  localparam int PH_IW     = (PH_W > 1) ? $clog2(PH_W) : 1;

  if (MAX_LOG2_N < 1 || MAX_LOG2_N >= FRAC_BITS) begin : g_bad_max_log2_n
    $error("e_pow_engine: MAX_LOG2_N must satisfy 1 <= MAX_LOG2_N < FRAC_BITS");
  end
  if ((1 << K_W) <= MAX_LOG2_N) begin : g_bad_k_w
    $error("e_pow_engine: K_W too narrow for MAX_LOG2_N");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                          state_q;
  logic                            busy_q, done_q, err_q, ovf_q, mode_q;
  logic [K_W-1:0]                  k_q, iter_q;
  logic [WORDS-1:0][WORD_W-1:0]    x_q, result_q;
  // Only the product words that survive the fractional truncation are kept.
  logic [PH_W-1:0][WORD_W-1:0]     ph_q;
  logic [ACC_W-1:0]                acc_q;
  logic [CW-1:0]                   c_q;
  logic [IW-1:0]                   i_q;

  logic [IW-1:0]                   j_idx, i_first_d;
  logic                            col_last, mac_last, ph_wr;
  logic [PH_IW-1:0]                ph_idx;
  logic [2*WORD_W-1:0]             prod;
  logic [ACC_W-1:0]                acc_d;
  logic [WORDS-1:0][WORD_W-1:0]    x_init;
  logic                            k_bad, ovf_bits;
  logic [K_W-1:0]                  iter_d;

  always_comb begin
    int c, hi, lo;
    c         = int'(c_q);
    hi        = (c < WORDS) ? c : WORDS - 1;
    lo        = (c + 2 > WORDS) ? c + 2 - WORDS : 0;
    col_last  = (int'(i_q) == hi);
    mac_last  = col_last && (c == 2 * WORDS - 2);
    i_first_d = IW'(lo);
    j_idx     = IW'(c - int'(i_q));
    ph_wr     = (c >= FRAC_W);
    ph_idx    = PH_IW'(c - FRAC_W);
  end

  always_comb begin
    prod     = (2*WORD_W)'(x_q[i_q]) * (2*WORD_W)'(x_q[j_idx]);
    acc_d    = acc_q + ACC_W'(prod);
    x_init   = (TOT_W'(1) << FRAC_BITS) + (TOT_W'(1) << (FRAC_BITS - int'(k_q)));
    k_bad    = (log2_n == '0) || (int'(log2_n) > MAX_LOG2_N);
    iter_d   = iter_q + K_W'(1);
    ovf_bits = 1'b0;
    for (int j = WORDS; j < PH_W; j++) begin
      ovf_bits = ovf_bits | (|ph_q[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      iter_q   <= '0;
      x_q      <= '0;
      result_q <= '0;
      ph_q     <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      i_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q <= mode;
            k_q    <= log2_n;
            x_q    <= operand;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
            iter_q <= '0;
            if (k_bad) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (!mode_q) x_q <= x_init;
          acc_q   <= '0;
          c_q     <= '0;
          i_q     <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          if (col_last) begin
            if (ph_wr) ph_q[ph_idx] <= acc_d[WORD_W-1:0];
            acc_q <= acc_d >> WORD_W;
            c_q   <= c_q + CW'(1);
            i_q   <= i_first_d;
            if (mac_last) begin
              ph_q[PH_W-1] <= acc_d[2*WORD_W-1:WORD_W];
              state_q      <= S_WB;
            end
          end else begin
            acc_q <= acc_d;
            i_q   <= i_q + IW'(1);
          end
        end
        S_WB: begin
          x_q    <= ph_q[WORDS-1:0];
          ovf_q  <= ovf_q | ovf_bits;
          iter_q <= iter_d;
          if (iter_d == k_q) begin
            state_q  <= S_DONE;
            result_q <= ph_q[WORDS-1:0];
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            acc_q   <= '0;
            c_q     <= '0;
            i_q     <= '0;
            state_q <= S_MAC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign ovf    = ovf_q;
  assign iter   = iter_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_e_pow_engine.sv
`default_nettype none
// ============================================================================
// tb_e_pow_engine : directed vector bench for e_pow_engine
// Rev 1.0
// ============================================================================
module tb_e_pow_engine;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [4:0]        log2_n;
  logic [7:0][15:0]  operand;
  logic              busy, done, err, ovf;
  logic [4:0]        iter;
  logic [7:0][15:0]  result;

  int n_chk = 0;
  int n_err = 0;

  e_pow_engine dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .log2_n  (log2_n),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ovf     (ovf),
    .iter    (iter),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         m;
    logic [4:0]   k;
    logic [127:0] op;
    logic [127:0] res;
    logic         e;
    logic         o;
    int           cyc;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] sq_model(input logic [127:0] x);
    logic [255:0] p;
    p = {128'b0, x} * {128'b0, x};
    return p[239:112];
  endfunction

  // Issue one start, scramble the inputs after acceptance, and wait for done.
  task automatic launch(input logic m, input logic [4:0] k, input logic [127:0] op,
                        output int cyc, output logic busy1);
    @(negedge clk);
    start = 1'b1; mode = m; log2_n = k; operand = op;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; log2_n = 5'd7; operand = ~op;
    cyc = 0; busy1 = 1'b0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (done) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    logic b1;
    launch(v.m, v.k, v.op, cyc, b1);
    chk($sformatf("v%0d_latency", idx), cyc, v.cyc);
    chk($sformatf("v%0d_busy_t1", idx), b1, !v.e);
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_err", idx), err, v.e);
    chk($sformatf("v%0d_ovf", idx), ovf, v.o);
    chk($sformatf("v%0d_iter", idx), iter, v.e ? 5'd0 : v.k);
    chk($sformatf("v%0d_busy_done", idx), busy, 1'b0);
  endtask

  initial begin
    logic [127:0] model, prev_res;
    logic [63:0]  diff;
    int           cyc, prev_it;
    logic         mono, stable;

    tv[0] = '{1'b0, 5'd1,  128'h0,                                       128'h0002_4000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 67};
    tv[1] = '{1'b0, 5'd2,  128'h0,                                       128'h0002_7100_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 132};
    tv[2] = '{1'b1, 5'd3,  128'h0001_8000_0000_0000_0000_0000_0000_0000, 128'h0019_A100_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 197};
    tv[3] = '{1'b1, 5'd16, 128'h1234_5678_0000_0000_0000_0000_0000_0000, 128'h0019_A100_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0, 1};
    tv[4] = '{1'b1, 5'd1,  128'h00FF_0000_0000_0000_0000_0000_0000_0000, 128'hFE01_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0, 67};
    tv[5] = '{1'b1, 5'd1,  128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 67};
    tv[6] = '{1'b1, 5'd1,  128'h0001_0000_0000_0000_0000_0000_0000_0001, 128'h0001_0000_0000_0000_0000_0000_0000_0002, 1'b0, 1'b0, 67};
    tv[7] = '{1'b1, 5'd2,  128'h0100_0000_0000_0000_0000_0000_0000_0000, 128'h0,                                       1'b0, 1'b1, 132};
    tv[8] = '{1'b0, 5'd0,  128'h0,                                       128'h0,                                       1'b1, 1'b0, 1};

    rst = 1'b1; start = 1'b0; mode = 1'b0; log2_n = '0; operand = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {busy, done, err, ovf, iter}, '0);
    chk("reset_result", result, '0);

    for (int i = 0; i < 9; i++) run_vec(tv[i], i);

    // k=15 e-series with a start pulse while busy; result must follow the model.
    model = (128'd1 << 112) + (128'd1 << 97);
    for (int i = 0; i < 15; i++) model = sq_model(model);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; log2_n = 5'd15; operand = '0;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; prev_it = 0; mono = 1'b1; stable = 1'b1; prev_res = result;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 300) begin start = 1'b1; mode = 1'b1; log2_n = 5'd1; operand = '1; end
      else start = 1'b0;
      if (done) break;
      if (result !== prev_res) stable = 1'b0;
      if (int'(iter) != prev_it) begin
        if (int'(iter) != prev_it + 1) mono = 1'b0;
        prev_it = int'(iter);
      end
    end
    start = 1'b0;
    chk("e15_latency", cyc, 977);
    chk("e15_result", result, model);
    chk("e15_err_ovf", {err, ovf}, 2'b00);
    chk("e15_iter_steps", mono, 1'b1);
    chk("e15_iter_final", iter, 5'd15);
    chk("e15_result_held", stable, 1'b1);
    diff = 64'h0002_B7E1_5162_8AED - result[7:4];
    chk("e15_bound", (diff > 0) && (diff < (64'd1 << 34)), 1'b1);

    // Reset in the middle of a multiply pass.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; log2_n = 5'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", {busy, done, err, ovf, iter}, '0);
    chk("mid_rst_result", result, '0);
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {busy, done}, 2'b00);
    run_vec(tv[0], 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
